// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding and default parameters for the performance monitor.
package perf_pkg;
    localparam int ST_W        = 2;
    localparam int DEF_NUM_EVT = 4;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_LIM_W   = 16;
    localparam int DEF_SEL_W   = 4;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: one counter with synchronous clear, wrap/saturate overflow and a sticky overflow flag.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             sat_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full;
    always_comb begin
        full  = &cnt_q;
        cnt_d = clr_i ? '0 : (!inc_i || (full && sat_i)) ? cnt_q : cnt_q + 1'b1;
        ovf_d = !clr_i && (ovf_q || (inc_i && full));
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle and event counters with limit, freeze, snapshot shadows and registered readout.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT = DEF_NUM_EVT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LIM_W   = DEF_LIM_W,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               freeze_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [NUM_EVT-1:0] evt_en_i,
    input  logic               mode_sat_i,
    input  logic [LIM_W-1:0]   limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               done_o,
    output logic [1:0]         state_o
);
    localparam int CW = CNT_W > LIM_W ? CNT_W : LIM_W;
    state_e                    state_q, state_d;
    logic [NUM_EVT:0][CNT_W-1:0] live, shadow_q, shadow_d;
    logic [NUM_EVT:0]          inc, ovf;
    logic [CNT_W-1:0]          rd_q, rd_d, cyc_nxt;
    logic                      cnt_en, hit;
    always_comb begin
        cnt_en  = state_q == ST_RUN && start_i && !freeze_i && !clear_i;
        cyc_nxt = live[NUM_EVT] + 1'b1;
        // compare in the wider of the two widths so a short counter never aliases the limit
        hit     = cnt_en && limit_i != '0 && CW'(cyc_nxt) == CW'(limit_i);
        inc     = {cnt_en, evt_i & evt_en_i & {NUM_EVT{cnt_en}}};
        state_d = state_q;
        if (clear_i || !start_i) state_d = ST_IDLE;
        else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN:    state_d = freeze_i ? ST_FROZEN : hit ? ST_DONE : ST_RUN;
                ST_FROZEN: state_d = freeze_i ? ST_FROZEN : ST_RUN;
                ST_DONE:   state_d = ST_DONE;
            endcase
        end
        rd_d = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            shadow_d[k] = clear_i ? '0 : snap_i ? live[k] : shadow_q[k];
            if (!clear_i && rd_sel_i == SEL_W'(k)) rd_d = shadow_q[k];
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            rd_q     <= rd_d;
        end
    end
    for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[i]),
            .sat_i (mode_sat_i),
            .cnt_o (live[i]),
            .ovf_o (ovf[i])
        );
    end
    assign rd_o    = rd_q;
    assign cycle_o = live[NUM_EVT];
    assign ovf_o   = ovf;
    assign done_o  = state_q == ST_DONE;
    assign state_o = state_q;
endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: directed scoreboard bench for a full-width and a 4-bit-counter monitor.
module tb_perf_event_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, freeze, mode, snap;
    logic [3:0]  evt, en, sel;
    logic [15:0] limit;
    logic [31:0] rd, cyc;
    logic [4:0]  ovf;
    logic        done;
    logic [1:0]  st;
    logic        s_start, s_clear, s_mode, s_snap;
    logic [3:0]  s_evt, s_en, s_sel, s_rd, s_cyc;
    logic [4:0]  s_ovf;
    logic        s_done;
    logic [1:0]  s_st;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    always #5 clk = ~clk;
    perf_event_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .evt_i(evt), .evt_en_i(en), .mode_sat_i(mode), .limit_i(limit), .snap_i(snap),
        .rd_sel_i(sel), .rd_o(rd), .cycle_o(cyc), .ovf_o(ovf), .done_o(done), .state_o(st)
    );
    perf_event_monitor #(.CNT_W(4)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .freeze_i(1'b0),
        .evt_i(s_evt), .evt_en_i(s_en), .mode_sat_i(s_mode), .limit_i(16'd0), .snap_i(s_snap),
        .rd_sel_i(s_sel), .rd_o(s_rd), .cycle_o(s_cyc), .ovf_o(s_ovf), .done_o(s_done), .state_o(s_st)
    );
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask
    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %0h expected nothing", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: got %0h expected %0h", t, obs, e);
            end
        end
    endtask
    initial begin
        rst = 1'b0; start = 1'b1; clear = 1'b1; freeze = 1'b1; mode = 1'b1; snap = 1'b1;
        evt = 4'hF; en = 4'hF; sel = 4'd0; limit = 16'd5;
        s_start = 1'b0; s_clear = 1'b0; s_mode = 1'b0; s_snap = 1'b0;
        s_evt = 4'h0; s_en = 4'hF; s_sel = 4'd0;
        tick(2);
        expect_v("rst_rd", 0);    check(rd);
        expect_v("rst_cyc", 0);   check(cyc);
        expect_v("rst_ovf", 0);   check(32'(ovf));
        expect_v("rst_done", 0);  check(32'(done));
        expect_v("rst_state", 0); check(32'(st));
        rst = 1'b1; start = 1'b0; clear = 1'b0; freeze = 1'b0; mode = 1'b0; snap = 1'b0;
        evt = 4'h0; limit = 16'd0;
        tick();
        // ten counted cycles on channel 0
        start = 1'b1; evt = 4'b0001;
        tick();
        expect_v("start_no_count", 0); check(cyc);
        tick(10);
        expect_v("t1_cyc", 10);  check(cyc);
        expect_v("t1_state", 1); check(32'(st));
        evt = 4'h0; snap = 1'b1; sel = 4'd0;
        expect_v("t1_rd_old", 0);
        tick();
        check(rd);
        snap = 1'b0;
        expect_v("t1_rd_ch0", 10);
        tick();
        check(rd);
        sel = 4'd4;
        expect_v("t1_rd_cyc", 10);
        tick();
        check(rd);
        start = 1'b0; tick();
        clear = 1'b1; tick(); clear = 1'b0;
        // cycle limit of 20
        limit = 16'd20; evt = 4'hF; start = 1'b1;
        tick();
        tick(19);
        expect_v("lim_cyc19", 19); check(cyc);
        expect_v("lim_done19", 0); check(32'(done));
        tick();
        expect_v("lim_cyc20", 20);  check(cyc);
        expect_v("lim_done20", 1);  check(32'(done));
        expect_v("lim_state", 3);   check(32'(st));
        tick(10);
        expect_v("lim_hold_cyc", 20); check(cyc);
        expect_v("lim_hold_done", 1); check(32'(done));
        evt = 4'h0; snap = 1'b1; tick(); snap = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            sel = 4'(k);
            expect_v($sformatf("lim_shadow%0d", k), 20);
            tick();
            check(rd);
        end
        start = 1'b0; limit = 16'd0; tick();
        expect_v("idle_after_stop", 0); check(32'(st));
        clear = 1'b1; tick(); clear = 1'b0;
        // freeze for five edges in the middle of a run
        evt = 4'b0100; start = 1'b1; tick();
        tick(4);
        freeze = 1'b1; tick(5);
        expect_v("frz_state", 2); check(32'(st));
        expect_v("frz_cyc", 4);   check(cyc);
        freeze = 1'b0; tick();
        expect_v("frz_exit_state", 1); check(32'(st));
        tick(3);
        expect_v("frz_cyc7", 7); check(cyc);
        evt = 4'h0; sel = 4'd2; snap = 1'b1; tick(); snap = 1'b0;
        expect_v("frz_ch2", 7);
        tick();
        check(rd);
        start = 1'b0; tick();
        clear = 1'b1; tick(); clear = 1'b0;
        // enable mask
        en = 4'b0101; evt = 4'hF; start = 1'b1; tick();
        tick(8);
        evt = 4'h0; snap = 1'b1; tick(); snap = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 4'(k);
            expect_v($sformatf("mask_ch%0d", k), (k % 2 == 0) ? 32'd8 : 32'd0);
            tick();
            check(rd);
        end
        // clear wins over snapshot
        clear = 1'b1; snap = 1'b1; sel = 4'd0; tick();
        expect_v("clr_state", 0); check(32'(st));
        expect_v("clr_cyc", 0);   check(cyc);
        expect_v("clr_rd", 0);    check(rd);
        clear = 1'b0; snap = 1'b0; tick();
        expect_v("clr_restart", 1); check(32'(st));
        expect_v("clr_shadow0", 0); check(rd);
        // snapshot captures pre-increment value
        en = 4'hF; evt = 4'b1000; tick(5);
        snap = 1'b1; sel = 4'd3; tick();
        snap = 1'b0; evt = 4'h0;
        expect_v("snap_pre", 5);
        tick();
        check(rd);
        snap = 1'b1; tick(); snap = 1'b0;
        expect_v("snap_live", 6);
        tick();
        check(rd);
        sel = 4'd5;
        expect_v("sel5_zero", 0);
        tick();
        check(rd);
        sel = 4'd15;
        expect_v("sel15_zero", 0);
        tick();
        check(rd);
        expect_v("main_ovf", 0); check(32'(ovf));
        start = 1'b0; tick();
        // 4-bit counters: wrap then saturate
        s_start = 1'b1; s_evt = 4'b0010; tick();
        tick(18);
        s_evt = 4'h0;
        expect_v("wrap_ovf", 32'b10010); check(32'(s_ovf));
        s_snap = 1'b1; s_sel = 4'd1; tick(); s_snap = 1'b0;
        expect_v("wrap_ch1", 2);
        tick();
        check(32'(s_rd));
        s_clear = 1'b1; tick();
        expect_v("s_clr_ovf", 0);   check(32'(s_ovf));
        expect_v("s_clr_state", 0); check(32'(s_st));
        s_clear = 1'b0; s_mode = 1'b1; s_evt = 4'b0010; tick();
        tick(18);
        s_evt = 4'h0;
        expect_v("sat_cyc", 15); check(32'(s_cyc));
        s_snap = 1'b1; tick(); s_snap = 1'b0;
        expect_v("sat_ch1", 15);
        tick();
        check(32'(s_rd));
        expect_v("sat_ovf", 32'b10010); check(32'(s_ovf));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
